// File: rtl/mem_arbiter_if.sv
// Request/response and memory-bus bundle between the two core ports, the
// arbiter and the unified SRAM macro.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    // instruction-fetch port
    logic                  im_req;
    logic [9:0]            im_addr;
    logic                  im_gnt;
    logic [DATA_WIDTH-1:0] im_rdata;
    logic                  im_rvalid;

    // data port
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                  dm_gnt;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_rvalid;

    // memory macro side
    logic                  mem_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_in;
    logic [DATA_WIDTH-1:0] mem_out;

    // performance counter
    logic [15:0]           conflict_cnt;

    // arbiter view
    modport slave (
        input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_out,
        output im_gnt, im_rdata, im_rvalid, dm_gnt, dm_rdata, dm_rvalid,
        output mem_enable, mem_read, mem_write, mem_address, mem_in, conflict_cnt
    );

    // requesters and memory view
    modport master (
        output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_out,
        input  im_gnt, im_rdata, im_rvalid, dm_gnt, dm_rdata, dm_rvalid,
        input  mem_enable, mem_read, mem_write, mem_address, mem_in, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the fetch (IM)
// and data (DM) ports. One command per access slot; reads take an extra
// response cycle, writes allow immediate re-arbitration to the other port.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IM_BASE    = 12'hC00
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_IM = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    state_t                state_reg, state_next;
    logic                  owner_reg, owner_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  last_winner_reg, last_winner_next;
    logic [15:0]           conflict_cnt_reg, conflict_cnt_next;

    logic                  in_access;
    logic                  im_elig;
    logic                  dm_elig;
    logic                  contended;
    logic                  pick_dm;
    logic [ADDR_WIDTH-1:0] im_mem_addr;

    // The port owning the current ACCESS cycle is masked so it cannot win
    // the slot right behind its own write.
    assign in_access   = (state_reg == ACCESS);
    assign im_elig     = bus.im_req && !(in_access && owner_reg == OWNER_IM);
    assign dm_elig     = bus.dm_req && !(in_access && owner_reg == OWNER_DM);
    assign contended   = im_elig && dm_elig;
    assign pick_dm     = contended ? (last_winner_reg == OWNER_IM) : dm_elig;
    // Fetch window is relocated by IM_BASE and wraps within the address space.
    assign im_mem_addr = IM_BASE + ADDR_WIDTH'(bus.im_addr);

    // State and command registers; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            owner_reg        <= OWNER_IM;
            we_reg           <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            last_winner_reg  <= OWNER_DM;
            conflict_cnt_reg <= 16'd0;
        end else begin
            state_reg        <= state_next;
            owner_reg        <= owner_next;
            we_reg           <= we_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            last_winner_reg  <= last_winner_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    // Next state: read ACCESS always moves to RESP; every other cycle ends
    // in an arbitration that either loads a new command or falls to IDLE.
    always_comb begin
        state_next        = state_reg;
        owner_next        = owner_reg;
        we_next           = we_reg;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        last_winner_next  = last_winner_reg;
        conflict_cnt_next = conflict_cnt_reg;

        if (in_access && !we_reg) begin
            state_next = RESP;
        end else if (im_elig || dm_elig) begin
            state_next       = ACCESS;
            owner_next       = pick_dm;
            last_winner_next = pick_dm;
            we_next          = pick_dm && bus.dm_we;
            addr_next        = pick_dm ? bus.dm_addr : im_mem_addr;
            wdata_next       = pick_dm ? bus.dm_wdata : '0;
            if (contended && conflict_cnt_reg != 16'hFFFF) begin
                conflict_cnt_next = conflict_cnt_reg + 16'd1;
            end
        end else begin
            state_next = IDLE;
        end
    end

    // Outputs decoded from the registered state and command.
    always_comb begin
        bus.mem_enable  = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_in      = '0;
        bus.im_gnt      = 1'b0;
        bus.dm_gnt      = 1'b0;
        bus.im_rvalid   = 1'b0;
        bus.dm_rvalid   = 1'b0;
        bus.im_rdata    = '0;
        bus.dm_rdata    = '0;

        case (state_reg)
            ACCESS: begin
                bus.mem_enable  = 1'b1;
                bus.mem_read    = !we_reg;
                bus.mem_write   = we_reg;
                bus.mem_address = addr_reg;
                bus.mem_in      = we_reg ? wdata_reg : '0;
                bus.im_gnt      = (owner_reg == OWNER_IM);
                bus.dm_gnt      = (owner_reg == OWNER_DM);
            end
            RESP: begin
                if (owner_reg == OWNER_DM) begin
                    bus.dm_rvalid = 1'b1;
                    bus.dm_rdata  = bus.mem_out;
                end else begin
                    bus.im_rvalid = 1'b1;
                    bus.im_rdata  = bus.mem_out;
                end
            end
            default: ;
        endcase
    end

    assign bus.conflict_cnt = conflict_cnt_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .IM_BASE   (12'hE00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Power-up content of the SRAM: distinctive pattern, DEADBEEF at 0x1FF.
    function automatic logic [31:0] init_pat(input logic [11:0] a);
        return (a == 12'h1FF) ? 32'hDEADBEEF : {20'hC0FFE, a};
    endfunction

    // SRAM macro model: registered read data one cycle after a read command.
    logic [31:0] mem [0:4095];
    bit          mem_wr [0:4095];
    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_write) begin
            mem[bus.mem_address]    <= bus.mem_in;
            mem_wr[bus.mem_address] <= 1'b1;
        end
        if (bus.mem_enable && bus.mem_read)
            bus.mem_out <= mem_wr[bus.mem_address] ? mem[bus.mem_address] : init_pat(bus.mem_address);
    end

    // Reference memory contents as the requesters expect them.
    logic [31:0] ref_mem [0:4095];
    bit          ref_wr [0:4095];
    function automatic logic [31:0] ref_rd(input logic [11:0] a);
        return ref_wr[a] ? ref_mem[a] : init_pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_gnt"},   32'({bus.im_gnt, bus.dm_gnt}), 32'd0);
        chk({name, "_rv"},    32'({bus.im_rvalid, bus.dm_rvalid}), 32'd0);
        chk({name, "_mem"},   32'({bus.mem_enable, bus.mem_read, bus.mem_write}), 32'd0);
        chk({name, "_addr"},  32'(bus.mem_address), 32'd0);
        chk({name, "_min"},   bus.mem_in, 32'd0);
        chk({name, "_rdata"}, bus.im_rdata | bus.dm_rdata, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.im_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          dm;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [11:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    // One isolated transaction from an idle arbiter: grant in N+1, data in N+2.
    task automatic run_vec(input int idx, input vec_t v);
        logic gnt_seen, rv_seen;
        logic [31:0] rd;
        @(posedge clk); #1;
        if (v.dm) begin
            bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
        end else begin
            bus.im_req = 1'b1; bus.im_addr = v.addr[9:0];
        end
        @(negedge clk);
        chk($sformatf("v%0d_nogrant", idx), 32'({bus.im_gnt, bus.dm_gnt}), 32'd0);
        @(negedge clk);
        gnt_seen = v.dm ? bus.dm_gnt : bus.im_gnt;
        chk($sformatf("v%0d_gnt", idx), 32'({bus.im_gnt, bus.dm_gnt}), v.dm ? 32'd1 : 32'd2);
        chk($sformatf("v%0d_cmd", idx), 32'({bus.mem_enable, bus.mem_read, bus.mem_write}),
            32'({1'b1, !v.we, v.we}));
        chk($sformatf("v%0d_addr", idx), 32'(bus.mem_address), 32'(v.exp_addr));
        if (v.we) chk($sformatf("v%0d_min", idx), bus.mem_in, v.wdata);
        @(posedge clk); #1;
        bus.im_req = 1'b0; bus.dm_req = 1'b0;
        @(negedge clk);
        rv_seen = v.dm ? bus.dm_rvalid : bus.im_rvalid;
        rd      = v.dm ? bus.dm_rdata : bus.im_rdata;
        chk($sformatf("v%0d_rvalid", idx), 32'(rv_seen), 32'(!v.we));
        if (!v.we) chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
        if (v.we) begin
            ref_mem[v.exp_addr] = v.wdata;
            ref_wr[v.exp_addr]  = 1'b1;
        end
        if (!gnt_seen) $display("note: vector %0d grant missing", idx);
    endtask

    // Randomized-run model state (previous cycle's requests and decisions).
    bit          p_req_im, p_req_dm, p_gnt, p_who, p_rd, p_dm_we;
    logic [9:0]  p_im_addr;
    logic [11:0] p_dm_addr;
    logic [31:0] p_dm_wdata, p_rd_exp;
    bit          lastw;
    int          exp_conf;
    bit          g_now, who_now, we_now, rv_now, rv_who;
    logic [11:0] a_now;
    logic [31:0] wd_now, rd_exp_now, rv_data;

    int grants, rd_g, rv_cnt, prev, cur;

    initial begin
        bus.im_req = 0; bus.im_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0;

        vecs[0] = '{0, 0, 12'h3FF, 32'h0,        12'h1FF, 32'hDEADBEEF};
        vecs[1] = '{0, 0, 12'h000, 32'h0,        12'hE00, 32'hC0FFEE00};
        vecs[2] = '{0, 0, 12'h1FF, 32'h0,        12'hFFF, 32'hC0FFEFFF};
        vecs[3] = '{0, 0, 12'h200, 32'h0,        12'h000, 32'hC0FFE000};
        vecs[4] = '{1, 1, 12'h004, 32'h12345678, 12'h004, 32'h0};
        vecs[5] = '{1, 0, 12'h004, 32'h0,        12'h004, 32'h12345678};
        vecs[6] = '{1, 1, 12'hFFF, 32'h0BADF00D, 12'hFFF, 32'h0};
        vecs[7] = '{1, 0, 12'hFFF, 32'h0,        12'hFFF, 32'h0BADF00D};
        vecs[8] = '{1, 0, 12'h010, 32'h0,        12'h010, 32'hC0FFE010};

        // reset state
        repeat (2) @(negedge clk);
        chk_quiet("rst_hold");
        chk("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
        rst = 1'b0;

        // reset in the middle of a DM read ACCESS
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 12'h010;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt", 32'(bus.dm_gnt), 32'd1);
        rst = 1'b1;
        #1;
        chk_quiet("mid_rst");
        bus.dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rv", 32'({bus.dm_rvalid, bus.dm_gnt}), 32'd0);
        end
        chk("post_rst_cnt", 32'(bus.conflict_cnt), 32'd0);

        // simultaneous requests straight out of reset: IM first
        @(posedge clk); #1;
        bus.im_req = 1'b1; bus.im_addr = 10'h005;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 12'h010;
        @(negedge clk);
        chk("sim_nogrant", 32'({bus.im_gnt, bus.dm_gnt}), 32'd0);
        @(negedge clk);
        chk("sim_im_first", 32'({bus.im_gnt, bus.dm_gnt}), 32'd2);
        chk("sim_im_addr", 32'(bus.mem_address), 32'h00000E05);
        @(posedge clk); #1;
        bus.im_req = 1'b0;
        @(negedge clk);
        chk("sim_im_rv", 32'({bus.im_rvalid, bus.dm_gnt}), 32'd2);
        chk("sim_im_rdata", bus.im_rdata, 32'hC0FFEE05);
        chk("sim_dm_rdata0", bus.dm_rdata, 32'd0);
        @(negedge clk);
        chk("sim_dm_gnt", 32'({bus.im_gnt, bus.dm_gnt}), 32'd1);
        chk("sim_dm_addr", 32'(bus.mem_address), 32'h010);
        @(posedge clk); #1;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("sim_dm_rv", 32'(bus.dm_rvalid), 32'd1);
        chk("sim_dm_rdata", bus.dm_rdata, 32'hC0FFE010);
        chk("sim_cnt", 32'(bus.conflict_cnt), 32'd1);

        // directed single transactions
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // round-robin fairness: both ports always requesting
        @(posedge clk); #1;
        bus.im_req = 1'b1; bus.im_addr = 10'($urandom);
        bus.dm_req = 1'b1; bus.dm_we = 1'($urandom);
        bus.dm_addr = 12'h800 | 12'($urandom_range(0, 255)); bus.dm_wdata = $urandom;
        grants = 0; rd_g = 0; rv_cnt = 0; prev = -1;
        for (int c = 0; c < 80 && grants < 20; c++) begin
            @(negedge clk);
            cur = -1;
            chk("rr_one_gnt", 32'(bus.im_gnt & bus.dm_gnt), 32'd0);
            if (bus.im_gnt || bus.dm_gnt) begin
                cur = bus.dm_gnt ? 1 : 0;
                if (prev >= 0) chk("rr_alternate", 32'(cur), 32'(1 - prev));
                prev = cur;
                grants++;
                if (cur == 0 || !bus.dm_we) rd_g++;
            end
            if (bus.im_rvalid || bus.dm_rvalid) rv_cnt++;
            @(posedge clk); #1;
            if (cur == 0) bus.im_addr = 10'($urandom);
            if (cur == 1) begin
                bus.dm_we = 1'($urandom);
                bus.dm_addr = 12'h800 | 12'($urandom_range(0, 255));
                bus.dm_wdata = $urandom;
            end
        end
        bus.im_req = 1'b0; bus.dm_req = 1'b0;
        chk("rr_grants", 32'(grants), 32'd20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.im_rvalid || bus.dm_rvalid) rv_cnt++;
        end
        chk("rr_rvalid_cnt", 32'(rv_cnt), 32'(rd_g));

        // randomized run against the transaction-level model
        do_reset();
        p_req_im = 0; p_req_dm = 0; p_gnt = 0; p_who = 0; p_rd = 0; p_dm_we = 0;
        p_im_addr = 0; p_dm_addr = 0; p_dm_wdata = 0; p_rd_exp = 0;
        lastw = 1'b1; exp_conf = 0; rd_exp_now = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            g_now = 0; who_now = 0; we_now = 0; rv_now = 0; rv_who = 0;
            a_now = 0; wd_now = 0; rv_data = 0;
            if (p_gnt && p_rd) begin
                rv_now = 1; rv_who = p_who; rv_data = p_rd_exp;
            end else begin
                bit ei, ed;
                ei = p_req_im && !(p_gnt && !p_who);
                ed = p_req_dm && !(p_gnt && p_who);
                if (ei || ed) begin
                    g_now = 1;
                    if (ei && ed) begin
                        who_now = !lastw;
                        if (exp_conf < 65535) exp_conf++;
                    end else begin
                        who_now = ed;
                    end
                    lastw = who_now;
                    if (who_now) begin
                        a_now = p_dm_addr; we_now = p_dm_we; wd_now = p_dm_wdata;
                    end else begin
                        a_now = 12'((32'hE00 + 32'(p_im_addr)) % 4096);
                    end
                    if (we_now) begin
                        ref_mem[a_now] = wd_now; ref_wr[a_now] = 1'b1;
                    end else begin
                        rd_exp_now = ref_rd(a_now);
                    end
                end
            end
            // requesters: drop/replace a request the cycle after its grant
            if (p_gnt && !p_who) bus.im_req = 1'b0;
            if (p_gnt && p_who)  bus.dm_req = 1'b0;
            if (!bus.im_req && $urandom_range(0, 9) < 7) begin
                bus.im_req = 1'b1; bus.im_addr = 10'($urandom);
            end
            if (!bus.dm_req && $urandom_range(0, 9) < 7) begin
                bus.dm_req = 1'b1; bus.dm_we = 1'($urandom);
                bus.dm_addr = 12'($urandom_range(0, 31)); bus.dm_wdata = $urandom;
            end
            @(negedge clk);
            chk("rnd_im_gnt", 32'(bus.im_gnt), 32'(g_now && !who_now));
            chk("rnd_dm_gnt", 32'(bus.dm_gnt), 32'(g_now && who_now));
            if (g_now) begin
                chk("rnd_addr", 32'(bus.mem_address), 32'(a_now));
                chk("rnd_cmd", 32'({bus.mem_enable, bus.mem_read, bus.mem_write}),
                    32'({1'b1, !we_now, we_now}));
                if (we_now) chk("rnd_min", bus.mem_in, wd_now);
            end
            chk("rnd_im_rv", 32'(bus.im_rvalid), 32'(rv_now && !rv_who));
            chk("rnd_dm_rv", 32'(bus.dm_rvalid), 32'(rv_now && rv_who));
            if (rv_now) begin
                chk("rnd_rdata", rv_who ? bus.dm_rdata : bus.im_rdata, rv_data);
                chk("rnd_other_rdata", rv_who ? bus.im_rdata : bus.dm_rdata, 32'd0);
            end
            p_req_im = bus.im_req; p_req_dm = bus.dm_req;
            p_im_addr = bus.im_addr; p_dm_addr = bus.dm_addr;
            p_dm_we = bus.dm_we; p_dm_wdata = bus.dm_wdata;
            p_gnt = g_now; p_who = who_now; p_rd = g_now && !we_now;
            p_rd_exp = rd_exp_now;
        end
        chk("rnd_conflicts", 32'(bus.conflict_cnt), 32'(exp_conf));
        bus.im_req = 1'b0; bus.dm_req = 1'b0;
        repeat (4) @(negedge clk);

        // counter saturation from a preloaded near-full value
        force dut.conflict_cnt_reg = 16'hFFFE;
        @(negedge clk);
        release dut.conflict_cnt_reg;
        @(posedge clk); #1;
        bus.im_req = 1'b1; bus.im_addr = 10'h001;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 12'h002;
        @(negedge clk);
        @(negedge clk);
        chk("sat_first", 32'(bus.conflict_cnt), 32'h0000FFFF);
        repeat (8) @(negedge clk);
        chk("sat_stick", 32'(bus.conflict_cnt), 32'h0000FFFF);
        bus.im_req = 1'b0; bus.dm_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares a single-port unified SRAM between the core's instruction-fetch (IM) port and data (DM) port. Sits between the processor top level and the memory macro: it accepts independent IM and DM requests, issues at most one memory command per access slot with round-robin arbitration, routes read data back to the owning requester, and counts contention events for performance analysis.

## Interface
- ADDR_WIDTH, 12, shared memory word-address width
- DATA_WIDTH, 32, data width
- IM_BASE, 12'hC00, memory offset added to the IM address
---
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- im_req  in  1  fetch request, level; held until im_gnt
- im_addr  in  10  fetch word address, stable while im_req high
- im_gnt  out  1  one-cycle pulse: IM command on memory bus this cycle
- im_rdata  out  DATA_WIDTH  fetch data, valid when im_rvalid
- im_rvalid  out  1  one-cycle pulse, fetch data valid
- dm_req  in  1  data request, level; held until dm_gnt
- dm_we  in  1  1 = write, 0 = read; stable while dm_req high
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_gnt  out  1  one-cycle pulse: DM command on memory bus this cycle
- dm_rdata  out  DATA_WIDTH  read data, valid when dm_rvalid
- dm_rvalid  out  1  one-cycle pulse, read data valid
- mem_enable  out  1  memory access strobe
- mem_read  out  1  read command
- mem_write  out  1  write command
- mem_address  out  ADDR_WIDTH  memory address
- mem_in  out  DATA_WIDTH  memory write data
- mem_out  in  DATA_WIDTH  memory read data, valid the cycle after a read command
- conflict_cnt  out  16  saturating count of contended arbitrations

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration evaluated at the end of IDLE, RESP, and write-ACCESS cycles. Eligible = req high and not the requester granted in the current cycle (its req is still high at this edge).
- Winner selection: only one eligible wins; if both are eligible, the requester that is not `last_winner` wins. `last_winner` updates on every grant. After reset, `last_winner` = DM, so the first tie goes to IM.
- A winner moves the FSM to ACCESS with command registers loaded. With no winner, the FSM goes to IDLE.
- ACCESS (one cycle):
  - mem_enable=1; mem_read=~we, mem_write=we.
  - Owner's gnt=1.
  - IM address: mem_address = (IM_BASE + {2'b0,im_addr}) mod 2^ADDR_WIDTH, wrapping with no carry out. IM is always read.
  - DM address: mem_address = dm_addr; mem_in = dm_wdata for writes.
  - Read → RESP. Write → re-arbitrate as above.
- RESP (one cycle):
  - Memory bus idle.
  - Owner's rvalid=1; rdata = mem_out passthrough.
  - The other port's rvalid=0 and rdata=0.
- conflict_cnt: +1 at each arbitration where both are eligible; saturates at 16'hFFFF.

## Timing
- Reset (async, immediate):
  - state=IDLE; all mem_*, gnt, rvalid, rdata outputs 0.
  - conflict_cnt=0; last_winner=DM.
  - Any in-flight access is dropped: no rvalid follows, and no write occurs unless its ACCESS cycle already completed.
- mem_*, gnt, and rvalid are registered (FSM-decoded); rdata is combinational from mem_out in RESP.
- Latency from req rising in cycle N with the arbiter free:
  - gnt and command in N+1.
  - Read rvalid in N+2.
- Back-to-back throughput:
  - Reads: one per 2 cycles (ACCESS, RESP, ACCESS...).
  - Writes: one per cycle when the other requester is alternating or pending.
  - The same requester cannot win twice consecutively without an intervening non-owned cycle, because of masking.
- A requester may drop or change req the cycle after gnt. A new req asserted during RESP is eligible at the end of RESP.
- req deasserted before gnt: undefined usage. The arbiter samples only at arbitration edges; no abort is supported.

## Test plan
- Reset sequence:
  - Stimulus: assert rst mid-ACCESS of a DM read to 12'h010.
  - Required: all outputs 0 immediately; no dm_rvalid after release; conflict_cnt=0.
- Single fetch with base wrap:
  - Stimulus: IM_BASE=12'hE00, im_req with im_addr=10'h3FF.
  - Required: gnt next cycle, mem_address=12'h1FF, mem_read=1; im_rvalid the following cycle with im_rdata=mem_out (model returns 32'hDEADBEEF).
- DM write then read:
  - Stimulus: write 32'h12345678 to 12'h004, then read 12'h004.
  - Required: mem_write with mem_in=32'h12345678 in the first grant cycle; read returns 32'h12345678 with dm_rvalid 1 cycle after the second grant.
- Simultaneous requests from reset:
  - Stimulus: im_req and dm_req both held from the same cycle.
  - Required: IM granted first, DM granted in the cycle after IM's RESP; conflict_cnt=1.
- Round-robin fairness:
  - Stimulus: both ports continuously requesting writes/reads for 20 grants.
  - Required: grants strictly alternate IM/DM; the count of rvalid pulses matches the read grants.
- Counter saturation:
  - Stimulus: force 65540 contended arbitrations (or preload via hierarchical force to 16'hFFFE).
  - Required: conflict_cnt sticks at 16'hFFFF.
